// File: rtl/retire_commit_unit.sv
// retire_commit_unit: retires the ROB head into the ARF, free-tag list and an in-order store buffer; redirects fetch on mispredict.
// Optional RETIRE_PERF_CNT_EN adds perf_retired / perf_mispredict counters.
module retire_commit_unit #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 6,
  parameter int SB_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              rt_valid,
  input  logic              rt_spec_valid,
  input  logic [TAG_W-1:0]  rt_rd_tag,
  input  logic [4:0]        rt_rd_reg,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [2:0]        rt_instr_type,
  input  logic [DATA_W-1:0] rt_store_addr,
  input  logic [DATA_W-1:0] rt_store_data,
  input  logic              rt_flush,
  input  logic [DATA_W-1:0] rt_br_target,
  output logic              retire_en,
  output logic              arf_wen,
  output logic [4:0]        arf_waddr,
  output logic [DATA_W-1:0] arf_wdata,
  output logic              tag_rel_valid,
  output logic [TAG_W-1:0]  tag_rel,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              sb_empty,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_mispredict
`endif
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [2:0] T_STORE = 3'd4, T_BRANCH = 3'd5;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [PW:0] sb_head, sb_tail;
  logic [DATA_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic is_store, is_branch, sb_full, sb_push, sb_pop, mispredict;
  always_comb begin
    is_store      = rt_instr_type == T_STORE;
    is_branch     = rt_instr_type == T_BRANCH;
    sb_empty      = sb_head == sb_tail;
    sb_full       = (sb_head[PW] != sb_tail[PW]) && (sb_head[PW-1:0] == sb_tail[PW-1:0]);
    retire_en     = rt_valid & rt_spec_valid & (state == RUN) & ~(is_store & sb_full);
    arf_wen       = retire_en & ~is_store & ~is_branch & (|rt_rd_reg);
    arf_waddr     = arf_wen ? rt_rd_reg : '0;
    arf_wdata     = arf_wen ? rt_data : '0;
    tag_rel_valid = retire_en;
    tag_rel       = retire_en ? rt_rd_tag : '0;
    mem_req       = ~sb_empty;
    mem_addr      = mem_req ? sb_addr[sb_head[PW-1:0]] : '0;
    mem_wdata     = mem_req ? sb_data[sb_head[PW-1:0]] : '0;
    sb_push       = retire_en & is_store;
    sb_pop        = mem_req & mem_ack;
    mispredict    = retire_en & rt_flush;
  end
  // Entry storage is not reset: validity is carried entirely by the pointers.
  always_ff @(posedge i_clk) begin
    if (sb_push) begin
      sb_addr[sb_tail[PW-1:0]] <= rt_store_addr;
      sb_data[sb_tail[PW-1:0]] <= rt_store_data;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= RUN;
      sb_head        <= '0;
      sb_tail        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= mispredict ? FLUSH : RUN;
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= rt_br_target;
      if (sb_push) sb_tail <= sb_tail + 1'b1;
      if (sb_pop) sb_head <= sb_head + 1'b1;
    end
  end
`ifdef RETIRE_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_retired    <= '0;
      perf_mispredict <= '0;
    end else begin
      if (retire_en) perf_retired <= perf_retired + 32'd1;
      if (mispredict) perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_retire_commit_unit.sv
// tb_retire_commit_unit: directed checks of retire, stall, store buffer ordering, mispredict redirect and reset.
module tb_retire_commit_unit;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        rt_valid = 0, rt_spec_valid = 0, rt_flush = 0, mem_ack = 0;
  logic [5:0]  rt_rd_tag = 0;
  logic [4:0]  rt_rd_reg = 0;
  logic [2:0]  rt_instr_type = 0;
  logic [31:0] rt_data = 0, rt_store_addr = 0, rt_store_data = 0, rt_br_target = 0;
  logic        retire_en, arf_wen, tag_rel_valid, mem_req, sb_empty, redirect_valid;
  logic [4:0]  arf_waddr;
  logic [5:0]  tag_rel;
  logic [31:0] arf_wdata, mem_addr, mem_wdata, redirect_pc;
`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] perf_retired, perf_mispredict;
`endif
  int checks = 0, failures = 0;

  retire_commit_unit dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .rt_valid(rt_valid), .rt_spec_valid(rt_spec_valid), .rt_rd_tag(rt_rd_tag),
    .rt_rd_reg(rt_rd_reg), .rt_data(rt_data), .rt_instr_type(rt_instr_type),
    .rt_store_addr(rt_store_addr), .rt_store_data(rt_store_data), .rt_flush(rt_flush),
    .rt_br_target(rt_br_target), .retire_en(retire_en), .arf_wen(arf_wen),
    .arf_waddr(arf_waddr), .arf_wdata(arf_wdata), .tag_rel_valid(tag_rel_valid),
    .tag_rel(tag_rel), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .sb_empty(sb_empty), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef RETIRE_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_mispredict(perf_mispredict)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_retire_en", retire_en, 0);
    chk("rst_sb_empty", sb_empty, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_tag_rel_valid", tag_rel_valid, 0);
    tick;
    i_rst = 0;
    tick;
    // INT retire
    rt_valid = 1; rt_spec_valid = 1; rt_rd_tag = 12; rt_rd_reg = 5;
    rt_data = 32'hDEADBEEF; rt_instr_type = 0;
    #2;
    chk("int_retire_en", retire_en, 1);
    chk("int_arf_wen", arf_wen, 1);
    chk("int_arf_waddr", arf_waddr, 5);
    chk("int_arf_wdata", arf_wdata, 32'hDEADBEEF);
    chk("int_tag_rel_valid", tag_rel_valid, 1);
    chk("int_tag_rel", tag_rel, 12);
    // spec_valid low stalls retirement
    tick;
    rt_spec_valid = 0; rt_rd_tag = 13; rt_rd_reg = 7;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("wait_retire_en", retire_en, 0);
      chk("wait_tag_rel_valid", tag_rel_valid, 0);
      tick;
    end
    rt_spec_valid = 1; rt_rd_reg = 0;
    #2;
    chk("r0_retire_en", retire_en, 1);
    chk("r0_arf_wen", arf_wen, 0);
    chk("r0_tag_rel", tag_rel, 13);
    // five stores into a 4-deep buffer with no ack
    for (int i = 0; i < 5; i++) begin
      tick;
      rt_instr_type = 3'd4; rt_rd_tag = 6'(20 + i); rt_rd_reg = 9;
      rt_store_addr = 32'h1000 + 32'(4 * i); rt_store_data = 32'hA0 + 32'(i);
      #2;
      chk("st_retire_en", retire_en, (i < 4) ? 1 : 0);
      chk("st_arf_wen", arf_wen, 0);
      if (i == 1) begin
        chk("st_mem_req", mem_req, 1);
        chk("st_mem_addr0", mem_addr, 32'h1000);
      end
    end
    mem_ack = 1;
    tick;
    mem_ack = 0;
    #2;
    chk("st5_retire_en", retire_en, 1);
    chk("st5_tag_rel", tag_rel, 24);
    chk("st5_mem_addr", mem_addr, 32'h1004);
    tick;
    rt_valid = 0; mem_ack = 1;
    for (int j = 0; j < 4; j++) begin
      #2;
      chk("drain_mem_req", mem_req, 1);
      chk("drain_mem_addr", mem_addr, 32'h1004 + 32'(4 * j));
      chk("drain_mem_wdata", mem_wdata, 32'hA1 + 32'(j));
      tick;
    end
    mem_ack = 0;
    #2;
    chk("drain_sb_empty", sb_empty, 1);
    chk("drain_mem_req_low", mem_req, 0);
    // mispredicted branch
    rt_valid = 1; rt_instr_type = 3'd5; rt_flush = 1; rt_br_target = 32'h100;
    rt_rd_tag = 30; rt_rd_reg = 3;
    #2;
    chk("br_retire_en", retire_en, 1);
    chk("br_arf_wen", arf_wen, 0);
    chk("br_tag_rel", tag_rel, 30);
    chk("br_redirect_early", redirect_valid, 0);
    tick;
    rt_flush = 0; rt_instr_type = 0; rt_rd_tag = 31; rt_rd_reg = 4; rt_data = 32'h55;
    #2;
    chk("flush_redirect_valid", redirect_valid, 1);
    chk("flush_redirect_pc", redirect_pc, 32'h100);
    chk("flush_retire_en", retire_en, 0);
    tick;
    #2;
    chk("resume_retire_en", retire_en, 1);
    chk("resume_redirect_valid", redirect_valid, 0);
    chk("resume_arf_waddr", arf_waddr, 4);
    chk("resume_tag_rel", tag_rel, 31);
    tick;
`ifdef RETIRE_PERF_CNT_EN
    #2;
    chk("perf_retired", perf_retired, 9);
    chk("perf_mispredict", perf_mispredict, 1);
`endif
    // reset with two stores pending
    rt_instr_type = 3'd4; rt_store_addr = 32'h2000; rt_store_data = 32'h1; rt_rd_tag = 40;
    tick;
    rt_store_addr = 32'h2004; rt_store_data = 32'h2; rt_rd_tag = 41;
    tick;
    rt_valid = 0;
    #2;
    chk("pend_mem_req", mem_req, 1);
    chk("pend_mem_addr", mem_addr, 32'h2000);
    chk("pend_sb_empty", sb_empty, 0);
    i_rst = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_sb_empty", sb_empty, 1);
    chk("arst_redirect_pc", redirect_pc, 0);
`ifdef RETIRE_PERF_CNT_EN
    chk("arst_perf_retired", perf_retired, 0);
    chk("arst_perf_mispredict", perf_mispredict, 0);
`endif
    tick;
    i_rst = 0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
